// File: rtl/sequence_display_if.sv
// Handshake and display bus between the game controller and sequence_display.
// seg_n exists only when SEQDISP_SEVENSEG_EN is defined.
interface sequence_display_if;
  logic        start;
  logic        abort;
  logic [2:0]  LVL;
  logic [19:0] S_in;
  logic [3:0]  disp_digit;
  logic        disp_valid;
  logic        busy;
  logic        display_done;
`ifdef SEQDISP_SEVENSEG_EN
  logic [6:0]  seg_n;
`endif

`ifdef SEQDISP_SEVENSEG_EN
  modport master (
    output start, abort, LVL, S_in,
    input  disp_digit, disp_valid, busy, display_done, seg_n
  );
  modport slave (
    input  start, abort, LVL, S_in,
    output disp_digit, disp_valid, busy, display_done, seg_n
  );
`else
  modport master (
    output start, abort, LVL, S_in,
    input  disp_digit, disp_valid, busy, display_done
  );
  modport slave (
    input  start, abort, LVL, S_in,
    output disp_digit, disp_valid, busy, display_done
  );
`endif
endinterface

// File: rtl/sequence_display.sv
// Plays a latched 5-digit hex sequence back one digit at a time (show, then gap).
// Optional registered 7-segment decode of the shown digit: SEQDISP_SEVENSEG_EN.
module sequence_display #(
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst,
  sequence_display_if.slave sd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       num_q, num_d;
  logic [19:0]      seq_q, seq_d;
  logic [3:0]       disp_digit_q, disp_digit_d;
  logic             disp_valid_q, disp_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SEQDISP_SEVENSEG_EN
  logic [6:0]       seg_q, seg_d;
`endif

  function automatic logic [2:0] digit_count(input logic [2:0] lvl);
    case (lvl)
      3'd0:                         digit_count = 3'd1;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: digit_count = lvl;
      default:                      digit_count = 3'd5;
    endcase
  endfunction

  function automatic logic [3:0] seq_nibble(input logic [19:0] seq, input logic [2:0] idx);
    case (idx)
      3'd0:    seq_nibble = seq[19:16];
      3'd1:    seq_nibble = seq[15:12];
      3'd2:    seq_nibble = seq[11:8];
      3'd3:    seq_nibble = seq[7:4];
      3'd4:    seq_nibble = seq[3:0];
      default: seq_nibble = 4'h0;
    endcase
  endfunction

`ifdef SEQDISP_SEVENSEG_EN
  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    case (hex)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction
`endif

  // Playback sequencing; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    num_d   = num_q;
    seq_d   = seq_q;
    if (sd.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sd.start && !sd.abort) begin
            seq_d   = sd.S_in;
            num_d   = digit_count(sd.LVL);
            idx_d   = 3'd0;
            cnt_d   = SHOW_LOAD;
            state_d = S_SHOW;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHOW: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (idx_q == (num_q - 3'd1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = SHOW_LOAD;
            state_d = S_SHOW;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    disp_valid_d = (state_d == S_SHOW);
    disp_digit_d = disp_valid_d ? seq_nibble(seq_d, idx_d) : 4'h0;
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
`ifdef SEQDISP_SEVENSEG_EN
    seg_d        = disp_valid_d ? hex_to_seg(disp_digit_d) : 7'h7F;
`endif
  end

  // State, dwell counter, latched sequence and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      idx_q        <= 3'd0;
      num_q        <= 3'd0;
      seq_q        <= 20'h00000;
      disp_digit_q <= 4'h0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQDISP_SEVENSEG_EN
      seg_q        <= 7'h7F;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      seq_q        <= seq_d;
      disp_digit_q <= disp_digit_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SEQDISP_SEVENSEG_EN
      seg_q        <= seg_d;
`endif
    end
  end

  assign sd.disp_digit   = disp_digit_q;
  assign sd.disp_valid   = disp_valid_q;
  assign sd.busy         = busy_q;
  assign sd.display_done = done_q;
`ifdef SEQDISP_SEVENSEG_EN
  assign sd.seg_n        = seg_q;
`endif

endmodule

// File: tb/tb_sequence_display.sv
// Directed bench for sequence_display with SHOW_CYCLES=4, GAP_CYCLES=2.
// Also checks seg_n when SEQDISP_SEVENSEG_EN is defined.
module tb_sequence_display;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  sequence_display_if sd_if ();

  sequence_display #(
    .SHOW_CYCLES(4),
    .GAP_CYCLES (2),
    .CNT_W      (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sd (sd_if)
  );

  always #5 clk = ~clk;

`ifdef SEQDISP_SEVENSEG_EN
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`endif

  // Expected {disp_valid, disp_digit, busy, display_done} at cycle c after start (c=1 is first SHOW cycle).
  function automatic logic [6:0] exp_vec(input int c, input int n, input logic [19:0] seq);
    int k;
    logic [3:0] d;
    if (c >= 1 && c <= n * 6) begin
      k = c - 1;
      if ((k % 6) < 4) begin
        d = seq[19 - 4 * (k / 6) -: 4];
        return {1'b1, d, 1'b1, 1'b0};
      end
      return {1'b0, 4'h0, 1'b1, 1'b0};
    end
    if (c == n * 6 + 1) return {1'b0, 4'h0, 1'b1, 1'b1};
    return 7'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done} !== 7'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done});
    end
`ifdef SEQDISP_SEVENSEG_EN
    n_vec++;
    if (sd_if.seg_n !== 7'h7F) begin
      n_err++;
      $display("FAIL reset_seg: got %h want 7f", sd_if.seg_n);
    end
`endif
    rst = 1'b0;
    step();
  endtask

  // Starts playback and checks every cycle until well past display_done.
  // restart_at > 0 pulses start with a zeroed S_in/LVL during that cycle.
  task automatic play_and_check(input string name, input logic [2:0] lvl, input logic [19:0] seq,
                                input int exp_n, input int exp_done_cycle, input int restart_at);
    logic [6:0] got, exp;
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = -1;
    sd_if.LVL   = lvl;
    sd_if.S_in  = seq;
    sd_if.start = 1'b1;
    step();
    sd_if.start = 1'b0;
    for (int c = 1; c <= exp_n * 6 + 4; c++) begin
      got = {sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done};
      exp = exp_vec(c, exp_n, seq);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: got {v,dig,busy,done}=%b want %b", name, c, got, exp);
      end
`ifdef SEQDISP_SEVENSEG_EN
      n_vec++;
      if (sd_if.seg_n !== (exp[6] ? glyph[exp[5:2]] : 7'h7F)) begin
        n_err++;
        $display("FAIL %s_seg cycle %0d: got %h want %h", name, c, sd_if.seg_n,
                 exp[6] ? glyph[exp[5:2]] : 7'h7F);
      end
`endif
      if (sd_if.display_done === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == restart_at) begin
        sd_if.S_in  = 20'h00000;
        sd_if.LVL   = 3'd0;
        sd_if.start = 1'b1;
      end
      step();
      sd_if.start = 1'b0;
    end
    n_vec++;
    if (done_cnt != 1 || done_cyc != exp_done_cycle) begin
      n_err++;
      $display("FAIL %s_done: got %0d pulses at cycle %0d want 1 pulse at cycle %0d",
               name, done_cnt, done_cyc, exp_done_cycle);
    end
  endtask

  task automatic test_levels();
    play_and_check("lvl5", 3'd5, 20'h123AC, 5, 31, 0);
    play_and_check("lvl2", 3'd2, 20'h9F000, 2, 13, 0);
    play_and_check("lvl0", 3'd0, 20'h7B123, 1, 7, 0);
    play_and_check("lvl7", 3'd7, 20'hE4D59, 5, 31, 0);
  endtask

  task automatic test_restart_ignored();
    play_and_check("restart", 3'd5, 20'h123AC, 5, 31, 8);
  endtask

  task automatic test_abort();
    logic [6:0] got, exp;
    int done_seen;
    done_seen = 0;
    sd_if.LVL   = 3'd5;
    sd_if.S_in  = 20'h123AC;
    sd_if.start = 1'b1;
    step();
    sd_if.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      got = {sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done};
      exp = exp_vec(c, 5, 20'h123AC);
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL abort_pre cycle %0d: got %b want %b", c, got, exp);
      end
      if (c == 18) sd_if.abort = 1'b1;
      step();
    end
    sd_if.abort = 1'b0;
    n_vec++;
    if ({sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done} !== 7'h00) begin
      n_err++;
      $display("FAIL abort_next: got %b want 0000000",
               {sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done});
    end
    for (int c = 0; c < 30; c++) begin
      if (sd_if.display_done !== 1'b0 || sd_if.busy !== 1'b0) done_seen++;
      step();
    end
    n_vec++;
    if (done_seen != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", done_seen);
    end
  endtask

  task automatic test_abort_in_idle();
    int busy_seen;
    busy_seen = 0;
    sd_if.LVL   = 3'd3;
    sd_if.S_in  = 20'h55555;
    sd_if.start = 1'b1;
    sd_if.abort = 1'b1;
    step();
    sd_if.start = 1'b0;
    sd_if.abort = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (sd_if.busy !== 1'b0 || sd_if.disp_valid !== 1'b0) busy_seen++;
      step();
    end
    n_vec++;
    if (busy_seen != 0) begin
      n_err++;
      $display("FAIL abort_idle: got %0d busy cycles want 0", busy_seen);
    end
  endtask

  task automatic test_async_reset();
    sd_if.LVL   = 3'd5;
    sd_if.S_in  = 20'h123AC;
    sd_if.start = 1'b1;
    step();
    sd_if.start = 1'b0;
    step();
    n_vec++;
    if (sd_if.disp_valid !== 1'b1 || sd_if.disp_digit !== 4'h1) begin
      n_err++;
      $display("FAIL arst_pre: got valid=%b digit=%h want 1 1", sd_if.disp_valid, sd_if.disp_digit);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done} !== 7'h00) begin
      n_err++;
      $display("FAIL arst_clear: got %b want 0000000",
               {sd_if.disp_valid, sd_if.disp_digit, sd_if.busy, sd_if.display_done});
    end
    step();
    rst = 1'b0;
    step();
    play_and_check("replay", 3'd3, 20'h123AC, 3, 19, 0);
  endtask

  initial begin
    rst         = 1'b1;
    sd_if.start = 1'b0;
    sd_if.abort = 1'b0;
    sd_if.LVL   = 3'd0;
    sd_if.S_in  = 20'h00000;
    test_reset();
    test_levels();
    test_restart_ignored();
    test_abort();
    test_abort_in_idle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
